fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register, directly upstream of the ID-stage hazard logic.
- Generates the PC and issues in-order requests to instruction memory over a valid/ready interface with variable latency.
- Buffers returned instructions and presents them to ID.
- Obeys stall_IFID (hold) and flush (kill plus redirect) from the hazard unit.

---
 rtl/rv_pipe_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the RV front end.
package rv_pipe_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned ILEN             = 32;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched (pc, instr) pairs with synchronous clear.
module fetch_fifo
  import rv_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  push_data,
  output fetch_entry_t  head_c,
  output logic [CW-1:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: in-order imem fetch, response buffering, stall/flush.
// Optional FETCH_PERF_EN adds saturating stall/flush/drop performance counters.
module fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall_IFID,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_count,
  output logic [31:0]     perf_drop_count,
`endif
  output logic [ILEN-1:0] instr_ID,
  output logic [XLEN-1:0] pc_ID,
  output logic            valid_ID
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] pc_f;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] pcq [FIFO_DEPTH];
  logic [AW-1:0]   pcq_wr;
  logic [AW-1:0]   pcq_rd;

  logic            req_fire_c;
  logic            rsp_drop_c;
  logic            rsp_live_c;
  logic            fifo_push_c;
  logic            fifo_pop_c;
  logic            id_load_c;
  logic [SW-1:0]   occupancy_c;
  fetch_entry_t    fifo_head_c;
  fetch_entry_t    rsp_entry_c;
  fetch_entry_t    id_next_c;

  // Issue gate: in-flight plus buffered work must fit in the FIFO.
  assign occupancy_c    = SW'(outstanding) + SW'(fifo_count);
  assign imem_req_valid = reset_n && !flush && (occupancy_c < SW'(FIFO_DEPTH));
  assign imem_req_addr  = pc_f;
  assign req_fire_c     = imem_req_valid && imem_req_ready;

  assign rsp_drop_c  = imem_rsp_valid && (flush || (drop_cnt != '0));
  assign rsp_live_c  = imem_rsp_valid && !rsp_drop_c;
  assign rsp_entry_c = '{pc: pcq[pcq_rd], instr: imem_rsp_data};

  // IF/ID steering: flush > stall > FIFO head > bypass > bubble.
  always_comb begin
    fifo_push_c = 1'b0;
    fifo_pop_c  = 1'b0;
    id_load_c   = 1'b0;
    id_next_c   = '{pc: pc_ID, instr: NOP_INSTR};
    if (flush) begin
      id_load_c = 1'b0;
    end else if (stall_IFID) begin
      fifo_push_c = rsp_live_c;
    end else if (fifo_count != '0) begin
      fifo_pop_c  = 1'b1;
      fifo_push_c = rsp_live_c;
      id_load_c   = 1'b1;
      id_next_c   = fifo_head_c;
    end else if (rsp_live_c) begin
      id_load_c = 1'b1;
      id_next_c = rsp_entry_c;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (fifo_push_c),
    .pop       (fifo_pop_c),
    .push_data (rsp_entry_c),
    .head_c    (fifo_head_c),
    .count     (fifo_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_ID <= NOP_INSTR;
      pc_ID    <= '0;
      valid_ID <= 1'b0;
    end else if (flush || !stall_IFID) begin
      instr_ID <= id_next_c.instr;
      pc_ID    <= id_next_c.pc;
      valid_ID <= id_load_c;
    end
  end

  // PC, in-flight bookkeeping; the PC queue pops on every response, dropped or not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_f        <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      if (flush)           pc_f <= redirect_pc & ~XLEN'(3);
      else if (req_fire_c) pc_f <= pc_f + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire_c) - CW'(imem_rsp_valid);
      if (flush)           drop_cnt <= outstanding - CW'(imem_rsp_valid);
      else if (rsp_drop_c) drop_cnt <= drop_cnt - CW'(1);
      if (req_fire_c)      pcq_wr <= pcq_wr + AW'(1);
      if (imem_rsp_valid)  pcq_rd <= pcq_rd + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (req_fire_c) pcq[pcq_wr] <= pc_f;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
      perf_drop_count   <= '0;
    end else begin
      if (stall_IFID && !flush && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush && (perf_flush_count != '1))
        perf_flush_count <= perf_flush_count + 32'd1;
      if (rsp_drop_c && (perf_drop_count != '1))
        perf_drop_count <= perf_drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed phases plus random traffic vs a queue-based model.
`timescale 1ns/1ps
module tb_fetch_stage;
  import rv_pipe_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall_IFID = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] instr_ID;
  logic [31:0] pc_ID;
  logic        valid_ID;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
  logic [31:0] perf_drop_count;
`endif

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .stall_IFID        (stall_IFID),
    .flush             (flush),
    .redirect_pc       (redirect_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
`ifdef FETCH_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count),
    .perf_drop_count   (perf_drop_count),
`endif
    .instr_ID          (instr_ID),
    .pc_ID             (pc_ID),
    .valid_ID          (valid_ID)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: requests in flight, buffered responses, ID register, counters.
  typedef struct { logic [31:0] pc; bit stale; } inflight_t;
  typedef struct { logic [31:0] data; int due; } memrsp_t;

  inflight_t    infl[$];
  fetch_entry_t buf_q[$];
  logic [31:0]  m_pc_f;
  logic [31:0]  m_instr;
  logic [31:0]  m_pcid;
  bit           m_valid;
  logic [31:0]  m_stall_cnt;
  logic [31:0]  m_flush_cnt;
  logic [31:0]  m_drop_cnt;

  memrsp_t      mem_q[$];
  int           cyc = 0;
  int           seq = 0;
  int           lat_lo = 0;
  int           lat_hi = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    infl.delete();
    buf_q.delete();
    mem_q.delete();
    m_pc_f      = RESET_PC;
    m_instr     = NOP_INSTR;
    m_pcid      = '0;
    m_valid     = 1'b0;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
    m_drop_cnt  = '0;
  endtask

  task automatic check_perf(input string tag);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_stall"}, perf_stall_cycles, m_stall_cnt);
    chk({tag, "_perf_flush"}, perf_flush_count, m_flush_cnt);
    chk({tag, "_perf_drop"},  perf_drop_count,  m_drop_cnt);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Asynchronous reset in the middle of a clock phase, checked immediately.
  task automatic do_reset_async();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid_ID", 32'(valid_ID), 32'(1'b0));
    chk("rst_instr_ID", instr_ID, NOP_INSTR);
    chk("rst_pc_ID", pc_ID, 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'(1'b0));
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    check_perf("rst");
    stall_IFID = 1'b0;
    flush = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One clock: drive inputs, check outputs, advance memory and model.
  task automatic step(input bit st, input bit fl, input logic [31:0] rpc, input bit rdy);
    bit           rsp;
    bit           exp_v;
    logic [31:0]  rdata;
    fetch_entry_t e;
    inflight_t    h;
    @(negedge clock);
    cyc++;
    rsp   = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rdata = rsp ? mem_q[0].data : $urandom;
    stall_IFID     = st;
    flush          = fl;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;
    chk("valid_ID", 32'(valid_ID), 32'(m_valid));
    chk("instr_ID", instr_ID, m_instr);
    if (m_valid) chk("pc_ID", pc_ID, m_pcid);
    exp_v = !fl && ((infl.size() + buf_q.size()) < FETCH_FIFO_DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_v));
    if (exp_v) chk("req_addr", imem_req_addr, m_pc_f);
    check_perf("run");

    if (imem_req_valid && rdy) begin
      mem_q.push_back('{data: {seq[15:0], imem_req_addr[15:0]},
                        due: cyc + 1 + int'($urandom_range(lat_hi, lat_lo))});
      seq++;
    end
    if (rsp) void'(mem_q.pop_front());

    if (rsp && infl.size() > 0) begin
      h = infl.pop_front();
      if (h.stale || fl) begin
        m_drop_cnt = sat_inc(m_drop_cnt);
      end else begin
        e.pc    = h.pc;
        e.instr = rdata;
        buf_q.push_back(e);
      end
    end
    if (fl) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      buf_q.delete();
      m_instr     = NOP_INSTR;
      m_valid     = 1'b0;
      m_pc_f      = rpc & ~32'd3;
      m_flush_cnt = sat_inc(m_flush_cnt);
    end else begin
      if (st) begin
        m_stall_cnt = sat_inc(m_stall_cnt);
      end else if (buf_q.size() > 0) begin
        e       = buf_q.pop_front();
        m_instr = e.instr;
        m_pcid  = e.pc;
        m_valid = 1'b1;
      end else begin
        m_instr = NOP_INSTR;
        m_valid = 1'b0;
      end
      if (exp_v && rdy) begin
        infl.push_back('{pc: m_pc_f, stale: 1'b0});
        m_pc_f = m_pc_f + 32'd4;
      end
    end
  endtask

  task automatic random_steps(input int n);
    logic [31:0] rpc;
    for (int i = 0; i < n; i++) begin
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                         : ($urandom & 32'h0000_FFFF);
      step($urandom_range(99, 0) < 25, $urandom_range(99, 0) < 8, rpc,
           $urandom_range(99, 0) < 70);
    end
  endtask

  initial begin
    model_reset();
    do_reset_async();

    // Streaming, single-cycle latency.
    lat_lo = 0; lat_hi = 0;
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Stall held three cycles mid-stream, then resume.
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Longer latency builds two outstanding requests, then flush to 0x100.
    lat_lo = 3; lat_hi = 3;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Memory not ready for four cycles.
    lat_lo = 0; lat_hi = 1;
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect with misaligned low bits and near address wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFF7, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    lat_lo = 0; lat_hi = 3;
    random_steps(3000);

    // Reset mid-burst, then restart from the reset PC.
    do_reset_async();
    lat_lo = 0; lat_hi = 0;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Five stalls, then a flush discarding two in-flight responses.
    do_reset_async();
    lat_lo = 3; lat_hi = 3;
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
    chk("perf_stall_total", perf_stall_cycles, 32'd5);
    chk("perf_flush_total", perf_flush_count, 32'd1);
    chk("perf_drop_total", perf_drop_count, 32'd2);
`endif

    lat_lo = 0; lat_hi = 3;
    random_steps(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
